pwm_duty_sequencer: RTL and testbench
=====================================

Name: pwm_duty_sequencer

Overview:
- Controller sitting in front of the PWM duty register.
- Accepts a target duty plus a ramp rate over a valid/ready handshake, then steps the live duty value by ±1 toward the target.
- Every step lands on a PWM period boundary, giving soft-start/soft-stop without mid-period glitches.
- The PWM generator consumes duty_out and supplies a period_start pulse at each counter wrap.

Parameters:
- DUTY_W, 4, width of duty values.
- PERIOD, 10, PWM period in clk cycles; legal duty range is 0..PERIOD.
- INIT_DUTY, 5, duty_out value after reset.
- DIV_W, 8, width of the ramp divider (periods held per step).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- period_start  in  1  one-cycle pulse from the PWM counter at period wrap
- cfg_valid  in  1  new ramp request present
- cfg_ready  out  1  sequencer can accept a request
- cfg_target  in  DUTY_W  requested final duty
- cfg_div  in  DIV_W  extra periods to hold between steps (0 = step every period)
- abort  in  1  stop the ramp and freeze the current duty
- duty_out  out  DUTY_W  live duty value to the PWM generator
- duty_load  out  1  one-cycle pulse on the cycle duty_out changes
- busy  out  1  ramp in progress
- done  out  1  one-cycle pulse when the target is reached

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, duty_out=INIT_DUTY, duty_load=0, busy=0, done=0, hold_cnt=0, target=INIT_DUTY. cfg_ready=1 in the first cycle after rst deasserts.
- FSM states: IDLE, RAMP, DONE.
- IDLE:
  - cfg_ready=1, busy=0.
  - On cfg_valid&cfg_ready, latch target=min(cfg_target,PERIOD) and div=cfg_div, and load hold_cnt=cfg_div.
  - If latched target==duty_out, go to DONE. Otherwise go to RAMP.
  - abort is ignored in IDLE.
- RAMP:
  - cfg_ready=0, busy=1. cfg_valid is ignored and the requester must hold it until accepted.
  - On period_start with hold_cnt==0:
    - duty_out <= duty_out+1 if target>duty_out, else duty_out-1.
    - duty_load=1 on the following cycle, coincident with the new duty_out.
    - hold_cnt <= div.
    - If the new duty_out==target, go to DONE.
  - On period_start with hold_cnt>0: hold_cnt <= hold_cnt-1, no step.
  - No period_start: hold.
  - abort=1 (any cycle, including coincident with period_start): no step, duty_out frozen, go to IDLE, no done pulse. Abort takes priority over stepping.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. cfg_ready=0 in DONE.
- Step latency:
  - First step occurs on the (cfg_div+1)-th period_start after acceptance.
  - A full ramp of N steps takes N*(cfg_div+1) period_start pulses.
- Arithmetic:
  - Steps are ±1 only. duty_out never leaves 0..PERIOD and never overshoots target.
  - No wrap-around at 0 or PERIOD. The comparison is unsigned, DUTY_W bits.
- Reset mid-ramp: duty_out returns to INIT_DUTY immediately, pending request discarded.

Optional Feature:
- Macro: PWM_SEQ_CLAMP_ERR_EN.
- Defined:
  - Adds output port cfg_err (1 bit, reset 0).
  - cfg_err pulses for one cycle, coincident with acceptance, when cfg_target>PERIOD.
  - The clamped request still executes normally.
- Undefined: port absent; out-of-range targets are silently clamped to PERIOD.

Test Plan:
- Reset then idle 20 cycles, period_start every 10 clk -> duty_out=5, busy=0, done=0, cfg_ready=1, no duty_load.
- Accept target=8, div=0 -> duty_out goes 6,7,8 on the 1st/2nd/3rd period_start, 3 duty_load pulses, done pulses once after the step to 8, busy low afterward.
- Accept target=2, div=2 -> one decrement per 3 period_starts (5→4→3→2 over 9 period_starts), done once, cfg_ready=0 throughout RAMP.
- Ramp to 10, assert abort coincident with the 2nd period_start -> duty_out stays 6 (no step to 7), state IDLE, no done, next request accepted.
- Accept target=5 while duty_out=5 -> done pulses 1 cycle after acceptance, no duty_load.
- Accept target=15, with and without PWM_SEQ_CLAMP_ERR_EN -> ramps to 10 and stops; with the macro, cfg_err=1 for exactly the acceptance cycle.

Source files
------------

// File: rtl/pwm_duty_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pwm_duty_sequencer
// Description : Ramps the live PWM duty by +/-1 toward a requested target,
//               stepping only on PWM period boundaries (soft start/stop).
//               Optional macro PWM_SEQ_CLAMP_ERR_EN adds a cfg_err pulse
//               for out-of-range targets.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_duty_sequencer #(
  parameter int DUTY_W    = 4,
  parameter int PERIOD    = 10,
  parameter int INIT_DUTY = 5,
  parameter int DIV_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              period_start,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DUTY_W-1:0] cfg_target,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              abort,
  output logic [DUTY_W-1:0] duty_out,
  output logic              duty_load,
  output logic              busy,
  output logic              done
`ifdef PWM_SEQ_CLAMP_ERR_EN
  ,
  output logic              cfg_err
`endif
);

  localparam logic [DUTY_W-1:0] c_period    = DUTY_W'(PERIOD);
  localparam logic [DUTY_W-1:0] c_init_duty = DUTY_W'(INIT_DUTY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [DUTY_W-1:0]   r_duty;
  logic [DUTY_W-1:0]   r_target;
  logic [DIV_W-1:0]    r_div;
  logic [DIV_W-1:0]    r_hold_cnt;
  logic                r_duty_load;
  logic                r_busy;
  logic                r_done;
  logic                r_cfg_ready;

  logic                w_accept;
  logic                w_step;
  logic                w_hold_dec;
  logic [DUTY_W-1:0]   w_target_clamped;
  logic [DUTY_W-1:0]   w_duty_next;

  // Next-state and per-cycle control decode.
  always_comb begin
    w_next_state     = r_state;
    w_accept         = 1'b0;
    w_step           = 1'b0;
    w_hold_dec       = 1'b0;
    w_target_clamped = (cfg_target > c_period) ? c_period : cfg_target;
    w_duty_next      = (r_target > r_duty) ? (r_duty + 1'b1) : (r_duty - 1'b1);

    case (r_state)
      ST_IDLE: begin
        if (cfg_valid && r_cfg_ready) begin
          w_accept     = 1'b1;
          w_next_state = (w_target_clamped == r_duty) ? ST_DONE : ST_RAMP;
        end
      end
      ST_RAMP: begin
        // Abort wins over a coincident period boundary: duty stays frozen.
        if (abort) begin
          w_next_state = ST_IDLE;
        end else if (period_start) begin
          if (r_hold_cnt == '0) begin
            w_step = 1'b1;
            if (w_duty_next == r_target) begin
              w_next_state = ST_DONE;
            end
          end else begin
            w_hold_dec = 1'b1;
          end
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_duty      <= c_init_duty;
      r_target    <= c_init_duty;
      r_div       <= '0;
      r_hold_cnt  <= '0;
      r_duty_load <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_ready <= 1'b1;
    end else begin
      r_state     <= w_next_state;
      r_duty_load <= w_step;
      r_busy      <= (w_next_state == ST_RAMP);
      r_done      <= (w_next_state == ST_DONE);
      r_cfg_ready <= (w_next_state == ST_IDLE);

      if (w_accept) begin
        r_target   <= w_target_clamped;
        r_div      <= cfg_div;
        r_hold_cnt <= cfg_div;
      end else if (w_step) begin
        r_duty     <= w_duty_next;
        r_hold_cnt <= r_div;
      end else if (w_hold_dec) begin
        r_hold_cnt <= r_hold_cnt - 1'b1;
      end
    end
  end

`ifdef PWM_SEQ_CLAMP_ERR_EN
  logic r_cfg_err;

  // Registered like every other output: high in the cycle right after the
  // accepting edge, the same cycle busy/done first reflect the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_accept && (cfg_target > c_period);
    end
  end

  assign cfg_err = r_cfg_err;
`endif

  assign cfg_ready = r_cfg_ready;
  assign duty_out  = r_duty;
  assign duty_load = r_duty_load;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_duty_sequencer
// Description : Directed self-checking bench for pwm_duty_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_sequencer;

  localparam int DUTY_W    = 4;
  localparam int PERIOD    = 10;
  localparam int INIT_DUTY = 5;
  localparam int DIV_W     = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              period_start;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [DUTY_W-1:0] cfg_target;
  logic [DIV_W-1:0]  cfg_div;
  logic              abort;
  logic [DUTY_W-1:0] duty_out;
  logic              duty_load;
  logic              busy;
  logic              done;
`ifdef PWM_SEQ_CLAMP_ERR_EN
  logic              cfg_err;
`endif

  int checks     = 0;
  int errors     = 0;
  int load_cnt   = 0;
  int done_cnt   = 0;
  int ready_viol = 0;

  always #5 clk = ~clk;

  pwm_duty_sequencer #(
    .DUTY_W   (DUTY_W),
    .PERIOD   (PERIOD),
    .INIT_DUTY(INIT_DUTY),
    .DIV_W    (DIV_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .period_start(period_start),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_target  (cfg_target),
    .cfg_div     (cfg_div),
    .abort       (abort),
    .duty_out    (duty_out),
    .duty_load   (duty_load),
    .busy        (busy),
    .done        (done)
`ifdef PWM_SEQ_CLAMP_ERR_EN
    ,
    .cfg_err     (cfg_err)
`endif
  );

  // One clock; outputs observed 1 ns after the edge, pulses tallied.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (duty_load === 1'b1) load_cnt++;
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1 && cfg_ready !== 1'b0) ready_viol++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic ps_cycle();
    period_start = 1'b1;
    cycle();
    period_start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; period_start = 1'b0; cfg_valid = 1'b0; abort = 1'b0;
    cfg_target = '0; cfg_div = '0;
    cycle();
    cycle();
    rst = 1'b0;
    load_cnt = 0; done_cnt = 0; ready_viol = 0;
  endtask

  task automatic request(input logic [DUTY_W-1:0] t, input logic [DIV_W-1:0] d);
    int n = 0;
    while (cfg_ready !== 1'b1 && n < 20) begin
      cycle();
      n++;
    end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL request_ready_timeout: cfg_ready=%b expected 1", cfg_ready); end
    cfg_valid = 1'b1; cfg_target = t; cfg_div = d;
    cycle();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (duty_out !== 4'd5) begin errors++; $display("FAIL reset_duty: duty_out=%0d expected 5", duty_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: busy=%b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: done=%b expected 0", done); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: cfg_ready=%b expected 1", cfg_ready); end
    checks++; if (duty_load !== 1'b0) begin errors++; $display("FAIL reset_load: duty_load=%b expected 0", duty_load); end
`ifdef PWM_SEQ_CLAMP_ERR_EN
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err: cfg_err=%b expected 0", cfg_err); end
`endif
    for (int p = 0; p < 2; p++) begin
      ps_cycle();
      idle(9);
    end
    checks++; if (duty_out !== 4'd5) begin errors++; $display("FAIL idle_duty: duty_out=%0d expected 5", duty_out); end
    checks++; if (load_cnt !== 0) begin errors++; $display("FAIL idle_loads: count=%0d expected 0", load_cnt); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL idle_done: count=%0d expected 0", done_cnt); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: cfg_ready=%b expected 1", cfg_ready); end
  endtask

  task automatic test_ramp_up();
    do_reset();
    request(4'd8, 8'd0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL up_busy: busy=%b expected 1", busy); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL up_ready: cfg_ready=%b expected 0", cfg_ready); end
    for (int s = 6; s <= 8; s++) begin
      ps_cycle();
      checks++; if (duty_out !== 4'(s)) begin errors++; $display("FAIL up_step: duty_out=%0d expected %0d", duty_out, s); end
      checks++; if (duty_load !== 1'b1) begin errors++; $display("FAIL up_load: duty_load=%b expected 1 at step %0d", duty_load, s); end
      checks++; if (done !== (s == 8)) begin errors++; $display("FAIL up_done: done=%b expected %0d at step %0d", done, (s == 8), s); end
      idle(9);
    end
    checks++; if (load_cnt !== 3) begin errors++; $display("FAIL up_load_count: count=%0d expected 3", load_cnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL up_done_count: count=%0d expected 1", done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL up_busy_after: busy=%b expected 0", busy); end
    checks++; if (duty_out !== 4'd8) begin errors++; $display("FAIL up_final: duty_out=%0d expected 8", duty_out); end
  endtask

  task automatic test_ramp_down();
    int exp_duty[9] = '{5, 5, 4, 4, 4, 3, 3, 3, 2};
    do_reset();
    request(4'd2, 8'd2);
    for (int p = 0; p < 9; p++) begin
      ps_cycle();
      checks++; if (duty_out !== 4'(exp_duty[p])) begin errors++; $display("FAIL down_duty: ps=%0d duty_out=%0d expected %0d", p + 1, duty_out, exp_duty[p]); end
      idle(9);
    end
    checks++; if (load_cnt !== 3) begin errors++; $display("FAIL down_load_count: count=%0d expected 3", load_cnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL down_done_count: count=%0d expected 1", done_cnt); end
    checks++; if (ready_viol !== 0) begin errors++; $display("FAIL down_ready_in_ramp: violations=%0d expected 0", ready_viol); end
  endtask

  task automatic test_abort();
    do_reset();
    request(4'd10, 8'd0);
    ps_cycle();
    idle(9);
    checks++; if (duty_out !== 4'd6) begin errors++; $display("FAIL abort_pre: duty_out=%0d expected 6", duty_out); end
    abort = 1'b1; period_start = 1'b1;
    cycle();
    abort = 1'b0; period_start = 1'b0;
    checks++; if (duty_out !== 4'd6) begin errors++; $display("FAIL abort_duty: duty_out=%0d expected 6", duty_out); end
    checks++; if (duty_load !== 1'b0) begin errors++; $display("FAIL abort_load: duty_load=%b expected 0", duty_load); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: busy=%b expected 0", busy); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: cfg_ready=%b expected 1", cfg_ready); end
    idle(5);
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_done: count=%0d expected 0", done_cnt); end
    request(4'd7, 8'd0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_next_busy: busy=%b expected 1", busy); end
    ps_cycle();
    checks++; if (duty_out !== 4'd7) begin errors++; $display("FAIL abort_next_duty: duty_out=%0d expected 7", duty_out); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_next_done: done=%b expected 1", done); end
  endtask

  task automatic test_same_target();
    do_reset();
    request(4'd5, 8'd0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL same_done: done=%b expected 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL same_busy: busy=%b expected 0", busy); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL same_ready: cfg_ready=%b expected 0", cfg_ready); end
    cycle();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL same_done_width: done=%b expected 0", done); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL same_ready_after: cfg_ready=%b expected 1", cfg_ready); end
    checks++; if (load_cnt !== 0) begin errors++; $display("FAIL same_loads: count=%0d expected 0", load_cnt); end
  endtask

  task automatic test_clamp();
    do_reset();
    request(4'd15, 8'd0);
`ifdef PWM_SEQ_CLAMP_ERR_EN
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL clamp_err: cfg_err=%b expected 1", cfg_err); end
    cycle();
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL clamp_err_width: cfg_err=%b expected 0", cfg_err); end
`endif
    for (int s = 6; s <= 10; s++) begin
      ps_cycle();
      checks++; if (duty_out !== 4'(s)) begin errors++; $display("FAIL clamp_step: duty_out=%0d expected %0d", duty_out, s); end
      idle(9);
    end
    ps_cycle();
    checks++; if (duty_out !== 4'd10) begin errors++; $display("FAIL clamp_hold: duty_out=%0d expected 10", duty_out); end
    checks++; if (duty_load !== 1'b0) begin errors++; $display("FAIL clamp_no_load: duty_load=%b expected 0", duty_load); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL clamp_done_count: count=%0d expected 1", done_cnt); end
  endtask

  task automatic test_reset_mid_ramp();
    do_reset();
    request(4'd9, 8'd0);
    ps_cycle();
    ps_cycle();
    checks++; if (duty_out !== 4'd7) begin errors++; $display("FAIL midrst_pre: duty_out=%0d expected 7", duty_out); end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++; if (duty_out !== 4'd5) begin errors++; $display("FAIL midrst_duty: duty_out=%0d expected 5", duty_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: busy=%b expected 0", busy); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: cfg_ready=%b expected 1", cfg_ready); end
    load_cnt = 0;
    ps_cycle();
    idle(3);
    checks++; if (duty_out !== 4'd5) begin errors++; $display("FAIL midrst_discard: duty_out=%0d expected 5", duty_out); end
    checks++; if (load_cnt !== 0) begin errors++; $display("FAIL midrst_loads: count=%0d expected 0", load_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    request(4'd7, 8'd0);
    ps_cycle();
    ps_cycle();
    idle(2);
    load_cnt = 0; done_cnt = 0;
    request(4'd6, 8'd1);
    // Second request held on the bus during the ramp; taken once IDLE returns.
    cfg_valid = 1'b1; cfg_target = 4'd3; cfg_div = 8'd0;
    ps_cycle();
    checks++; if (duty_out !== 4'd7) begin errors++; $display("FAIL b2b_hold: duty_out=%0d expected 7", duty_out); end
    idle(9);
    ps_cycle();
    checks++; if (duty_out !== 4'd6) begin errors++; $display("FAIL b2b_first: duty_out=%0d expected 6", duty_out); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: done=%b expected 1", done); end
    idle(9);
    cfg_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_busy: busy=%b expected 1", busy); end
    for (int s = 5; s >= 3; s--) begin
      ps_cycle();
      checks++; if (duty_out !== 4'(s)) begin errors++; $display("FAIL b2b_second: duty_out=%0d expected %0d", duty_out, s); end
      idle(9);
    end
    checks++; if (load_cnt !== 4) begin errors++; $display("FAIL b2b_loads: count=%0d expected 4", load_cnt); end
    checks++; if (done_cnt !== 2) begin errors++; $display("FAIL b2b_done_count: count=%0d expected 2", done_cnt); end
  endtask

  initial begin
    rst = 1'b1; period_start = 1'b0; cfg_valid = 1'b0; abort = 1'b0;
    cfg_target = '0; cfg_div = '0;
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_abort();
    test_same_target();
    test_clamp();
    test_reset_mid_ramp();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
